// File: rtl/dot_operand_loader.sv
// Byte-stream front end for matrix_dot: assembles operands A and B, fires one dot
// product, waits for its done edge (or a watchdog) and offers the result on valid/ready.
module dot_operand_loader #(
  parameter int VEC_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 8191
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] a_out [0:VEC_LEN-1],
  output logic [DATA_W-1:0] b_out [0:VEC_LEN-1],
  output logic              dot_start,
  input  logic              dot_done,
  input  logic [RES_W-1:0]  dot_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_err,
  output logic              busy
);

  localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_FIRE   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  localparam logic [IW-1:0] IDX_LAST  = IW'(VEC_LEN - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WDOG_MAX  = {WW{1'b1}};

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              done_q, done_d;
  logic              dot_start_q, dot_start_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic [DATA_W-1:0] a_q [0:VEC_LEN-1];
  logic [DATA_W-1:0] a_d [0:VEC_LEN-1];
  logic [DATA_W-1:0] b_q [0:VEC_LEN-1];
  logic [DATA_W-1:0] b_d [0:VEC_LEN-1];

  logic accept;
  logic last_byte;
  logic done_edge;
  logic expired;

  assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign busy      = !((state_q == S_LOAD_A) && (idx_q == '0));
  assign accept    = in_valid && in_ready;
  assign last_byte = (idx_q == IDX_LAST);
  // dot_done is a level that may linger from a previous run; only a fresh rise counts.
  assign done_edge = dot_done && !done_q;
  assign expired   = (wdog_q == WDOG_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wdog_d      = wdog_q;
    done_d      = done_q;
    dot_start_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    a_d         = a_q;
    b_d         = b_q;

    case (state_q)
      S_LOAD_A: begin
        if (accept) begin
          a_d[idx_q] = in_data;
          if (last_byte) begin
            idx_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          b_d[idx_q] = in_data;
          if (last_byte) begin
            idx_d       = '0;
            state_d     = S_FIRE;
            dot_start_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_FIRE: begin
        wdog_d  = '0;
        done_d  = dot_done;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        done_d = dot_done;
        if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + WW'(1);
        end
        // A real done edge beats a watchdog expiry landing on the same cycle.
        if (done_edge) begin
          res_data_d  = dot_c;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else if (expired) begin
          res_data_d  = dot_c;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_LOAD_A;
        end
      end
      default: begin
        state_d = S_LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD_A;
      idx_q       <= '0;
      wdog_q      <= '0;
      done_q      <= 1'b0;
      dot_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdog_q      <= wdog_d;
      done_q      <= done_d;
      dot_start_q <= dot_start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign dot_start = dot_start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_dot_operand_loader.sv
// Directed bench for dot_operand_loader: table of operations (load, dot-unit behaviour,
// expected result/latency) plus hand-written async-reset and freeze sequences.
module tb_dot_operand_loader;

  localparam int VEC_LEN = 16;
  localparam int DATA_W  = 8;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 8191;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] a_out [0:VEC_LEN-1];
  logic [DATA_W-1:0] b_out [0:VEC_LEN-1];
  logic              dot_start;
  logic              dot_done;
  logic [RES_W-1:0]  dot_c;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              res_err;
  logic              busy;

  dot_operand_loader #(
    .VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a_out(a_out), .b_out(b_out),
    .dot_start(dot_start), .dot_done(dot_done), .dot_c(dot_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a_base;
    logic [7:0]  a_step;
    logic [7:0]  b_base;
    logic [7:0]  b_step;
    bit          gaps;      // idle cycle before every byte
    int          rise_at;   // cycle after FIRE (FIRE = 0) where dot_done rises, -1 = never
    bit          sticky;    // dot_done high from the start of the operation
    bit          junk;      // hold in_valid=1 with 0xFF during WAIT/RESULT
    int          hold;      // cycles res_ready stays low once res_valid is up
    logic [15:0] exp_data;
    bit          exp_err;
    int          exp_rv;    // cycle after FIRE where res_valid is first seen
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int errors = 0;

  vec_t        v;
  logic [7:0]  ea [VEC_LEN];
  logic [7:0]  eb [VEC_LEN];
  int          c, cap, mism;
  bit          bad_rdy, bad_ds, held_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gap);
    int w;
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'hEE;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  function automatic int count_mism_a();
    int m = 0;
    for (int i = 0; i < VEC_LEN; i++) if (a_out[i] !== ea[i]) m++;
    return m;
  endfunction

  function automatic int count_mism_b();
    int m = 0;
    for (int i = 0; i < VEC_LEN; i++) if (b_out[i] !== eb[i]) m++;
    return m;
  endfunction

  function automatic int count_nonzero();
    int m = 0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (a_out[i] !== 8'h00) m++;
      if (b_out[i] !== 8'h00) m++;
    end
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //            a_base a_step b_base b_step gaps rise     sticky junk hold exp_data  err rv
    vecs[0] = '{8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 40,      1'b0, 1'b0, 0,  16'h0088, 1'b0, 41};
    vecs[1] = '{8'hFF, 8'h00, 8'h01, 8'h01, 1'b1, 5,       1'b0, 1'b0, 10, 16'hFF78, 1'b0, 6};
    vecs[2] = '{8'h02, 8'h00, 8'h03, 8'h00, 1'b0, -1,      1'b1, 1'b0, 1,  16'h0060, 1'b1, TIMEOUT + 1};
    vecs[3] = '{8'h10, 8'h01, 8'h02, 8'h00, 1'b0, TIMEOUT, 1'b0, 1'b0, 0,  16'h02F0, 1'b0, TIMEOUT + 1};
    vecs[4] = '{8'h7F, 8'h00, 8'h80, 8'h00, 1'b0, 3,       1'b0, 1'b1, 2,  16'h0800, 1'b0, 4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    dot_done  = 1'b0;
    dot_c     = 16'hDEAD;
    res_ready = 1'b0;
    repeat (3) tick();
    check("rst_ab_zero", count_nonzero(), 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_dot_start", dot_start, 0);
    rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      v = vecs[r];
      dot_done = v.sticky;
      dot_c    = 16'hDEAD;
      for (int i = 0; i < VEC_LEN; i++) begin
        ea[i] = v.a_base + v.a_step * 8'(i);
        eb[i] = v.b_base + v.b_step * 8'(i);
      end
      for (int i = 0; i < VEC_LEN; i++) send_byte(ea[i], v.gaps);
      for (int i = 0; i < VEC_LEN; i++) send_byte(eb[i], v.gaps);

      check($sformatf("op%0d_a_out_mism", r), count_mism_a(), 0);
      check($sformatf("op%0d_b_out_mism", r), count_mism_b(), 0);
      check($sformatf("op%0d_dot_start_fire", r), dot_start, 1);
      check($sformatf("op%0d_in_ready_fire", r), in_ready, 0);

      if (v.junk) begin
        in_valid = 1'b1;
        in_data  = 8'hFF;
      end
      cap     = (v.rise_at >= 0) ? v.rise_at : TIMEOUT;
      c       = 0;
      bad_rdy = 1'b0;
      bad_ds  = 1'b0;
      while (!res_valid && c <= TIMEOUT + 4) begin
        if (c > 0 && dot_start) bad_ds = 1'b1;
        if (in_ready) bad_rdy = 1'b1;
        if (c == v.rise_at) dot_done = 1'b1;
        dot_c = (c == cap) ? v.exp_data : 16'hDEAD;
        tick();
        c++;
      end
      dot_c = 16'hBAD0;

      check($sformatf("op%0d_res_valid", r), res_valid, 1);
      check($sformatf("op%0d_latency", r), c, v.exp_rv);
      check($sformatf("op%0d_res_data", r), res_data, v.exp_data);
      check($sformatf("op%0d_res_err", r), res_err, v.exp_err);
      check($sformatf("op%0d_dot_start_pulse", r), bad_ds, 0);

      held_ok = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        tick();
        if (!res_valid || res_data !== v.exp_data || res_err !== v.exp_err || in_ready)
          held_ok = 1'b0;
      end
      check($sformatf("op%0d_result_held", r), held_ok, 1);
      check($sformatf("op%0d_in_ready_wait", r), bad_rdy, 0);

      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check($sformatf("op%0d_res_valid_clr", r), res_valid, 0);
      check($sformatf("op%0d_in_ready_after", r), in_ready, 1);
      check($sformatf("op%0d_busy_after", r), busy, 0);
      check($sformatf("op%0d_a_frozen", r), count_mism_a(), 0);
      check($sformatf("op%0d_b_frozen", r), count_mism_b(), 0);

      if (v.junk) begin
        tick();
        in_valid = 1'b0;
        in_data  = 8'hEE;
        check("freeze_ff_lands_a0", a_out[0], 8'hFF);
        check("freeze_busy", busy, 1);
      end

      $display("op %0d: res_data=0x%04h res_err=%0d latency=%0d", r, res_data, res_err, c);
    end

    // The 0xFF from the freeze test is a[0]; finish A, push 5 B bytes, then reset mid-LOAD_B.
    for (int i = 1; i < VEC_LEN; i++) send_byte(8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b0);
    check("t1_b4_loaded", b_out[4], 8'h35);
    check("t1_busy_pre", busy, 1);
    rst_n = 1'b0;
    #2;
    check("t1_ab_zero", count_nonzero(), 0);
    check("t1_res_data", res_data, 0);
    check("t1_res_err", res_err, 0);
    check("t1_res_valid", res_valid, 0);
    check("t1_dot_start", dot_start, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    send_byte(8'h5A, 1'b0);
    check("t1_next_a0", a_out[0], 8'h5A);
    check("t1_next_a1", a_out[1], 8'h00);
    check("t1_next_b0", b_out[0], 8'h00);
    $display("reset: next byte a_out[0]=0x%02h", a_out[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
